// File: rtl/exu_pkg.sv
// Shared opcodes, FSM encoding and sizing for the execute stage.
// The EXU_DIV_EN macro enables the DIV/MOD datapath.
package exu_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_CNT_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd9;
  localparam logic [3:0] OP_MOD   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/exu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The divider half exists only when EXU_DIV_EN is defined.
module exu_muldiv_iter
  import exu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef EXU_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [ITER_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      m;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      acc_nx;
  logic                  last;

  assign acc_nx = acc + (q[0] ? m : '0);
  assign last   = (cnt == ITER_CNT_W'(WIDTH - 1));
  assign done   = busy & last;
  // Outputs are the post-step values so the caller can latch on done
  assign prod   = acc_nx;

`ifdef EXU_DIV_EN
  logic             div_q;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  assign r_sh = {r, q[WIDTH-1]};
  assign ge   = (r_sh >= {1'b0, m});
  assign diff = r_sh[WIDTH-1:0] - m;
  assign r_nx = ge ? diff : r_sh[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ge};
  assign quot = q_nx;
  assign rem  = r_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0;
      r     <= '0;
    end else if (start) begin
      div_q <= div;
      r     <= '0;
    end else if (busy) begin
      r     <= r_nx;
    end
  end
`else
  assign quot = '0;
  assign rem  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      m    <= '0;
      q    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
`ifdef EXU_DIV_EN
      m    <= div ? b : a;
      q    <= div ? a : b;
`else
      m    <= a;
      q    <= b;
`endif
    end else if (busy) begin
      cnt  <= cnt + 1'b1;
      busy <= ~last;
      acc  <= acc_nx;
`ifdef EXU_DIV_EN
      m    <= div_q ? m : (m << 1);
      q    <= div_q ? q_nx : (q >> 1);
`else
      m    <= m << 1;
      q    <= q >> 1;
`endif
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: 1-cycle ALU plus iterative MUL (and DIV/MOD with EXU_DIV_EN).
// Drives the register-file write port directly; no output backpressure.
module exec_unit
  import exu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RA_W-1:0]  rd_in,
  input  logic             wr_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [RA_W-1:0]  rd_out,
  output logic             wr_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             illegal
);

  logic [1:0]            state;
  logic [3:0]            op_q;
  logic [RA_W-1:0]       rd_q;
  logic                  wr_q;
  logic [WIDTH:0]        sum;
  logic [ITER_CNT_W-1:0] shamt;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c;
  logic                  alu_ill;
  logic                  is_multi;
  logic                  start;
  logic                  eng_busy;
  logic                  eng_done;
  logic [WIDTH-1:0]      prod;
  logic [WIDTH-1:0]      quot;
  logic [WIDTH-1:0]      rem;
  logic [WIDTH-1:0]      mres;

  assign in_ready = (state == ST_IDLE) & ~eng_busy;
  assign sum      = {1'b0, op_a} + {1'b0, op_b};
  assign shamt    = op_b[ITER_CNT_W-1:0];

`ifdef EXU_DIV_EN
  assign is_multi = (alu_op == OP_MUL) | (alu_op == OP_DIV) |
                    (alu_op == OP_MOD);
`else
  assign is_multi = (alu_op == OP_MUL);
`endif

  assign start = in_valid & in_ready & is_multi;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    unique case (alu_op)
      OP_ADD:   begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_SUB:   begin alu_res = op_a - op_b; alu_c = (op_a >= op_b); end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = WIDTH'($signed(op_a) >>> shamt);
      OP_PASSB: alu_res = op_b;
      // MUL never lands here; DIV/MOD land here only without the divider
      default:  alu_ill = 1'b1;
    endcase
  end

  exu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(start),
`ifdef EXU_DIV_EN
    .div  (alu_op != OP_MUL),
`endif
    .a    (op_a),
    .b    (op_b),
    .busy (eng_busy),
    .done (eng_done),
    .prod (prod),
    .quot (quot),
    .rem  (rem)
  );

  assign mres = (op_q == OP_DIV) ? quot :
                (op_q == OP_MOD) ? rem  : prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      wr_out    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      wr_out    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ITER;
            op_q  <= alu_op;
            rd_q  <= rd_in;
            wr_q  <= wr_in;
          end else if (in_valid) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            rd_out    <= rd_in;
            wr_out    <= wr_in & ~alu_ill;
            flag_z    <= (alu_res == '0);
            flag_n    <= alu_res[WIDTH-1];
            flag_c    <= alu_c;
            illegal   <= alu_ill;
          end
        end
        ST_ITER: begin
          if (eng_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= mres;
            rd_out    <= rd_q;
            wr_out    <= wr_q;
            flag_z    <= (mres == '0);
            flag_n    <= mres[WIDTH-1];
            flag_c    <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: table of 1-cycle ops plus multi-cycle sequences.
// Builds with or without EXU_DIV_EN.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  rd_in;
  logic        wr_in;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  rd_out;
  logic        wr_out;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .wr_in(wr_in), .out_valid(out_valid), .result(result),
    .rd_out(rd_out), .wr_out(wr_out), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .illegal(illegal)
  );

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        wr;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        ill;
    logic        wo;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm, logic [3:0] op, logic [31:0] a,
                              logic [31:0] b, logic [3:0] rd, logic wr,
                              logic [31:0] res, logic z, logic n, logic c,
                              logic ill, logic wo);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.rd = rd; v.wr = wr;
    v.res = res; v.z = z; v.n = n; v.c = c; v.ill = ill; v.wo = wo;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                       logic [3:0] rd, logic wr);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b; rd_in = rd; wr_in = wr;
  endtask

  task automatic apply_vec(vec_t v);
    @(negedge clk);
    drive(v.op, v.a, v.b, v.rd, v.wr);
    @(posedge clk); #1;
    chk(v.nm,
        {22'd0, out_valid, result, flag_z, flag_n, flag_c, illegal,
         wr_out, rd_out},
        {22'd0, 1'b1, v.res, v.z, v.n, v.c, v.ill, v.wo, v.rd});
  endtask

  task automatic run_multi(string nm, logic [3:0] op, logic [31:0] a,
                           logic [31:0] b, logic [31:0] exp);
    int bad;
    bad = 0;
    @(negedge clk);
    drive(op, a, b, 4'd9, 1'b1);
    @(posedge clk); #1;
    for (int k = 1; k <= 32; k++) begin
      if (in_ready || out_valid || wr_out) bad++;
      @(negedge clk);
      // Offer an ADD while busy; it must be dropped, not queued
      if (k <= 4) drive(4'd0, 32'd1, 32'd1, 4'd2, 1'b1);
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk({nm, "_busy"}, 64'(bad), 64'd0);
    chk({nm, "_done"},
        {24'd0, in_ready, out_valid, wr_out, illegal, rd_out, result},
        {24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, exp});
    @(posedge clk); #1;
    chk({nm, "_idle"}, {61'd0, in_ready, out_valid, wr_out},
        {61'd0, 3'b100});
  endtask

  initial begin
    int bad;
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; op_a = '0; op_b = '0;
    rd_in = '0; wr_in = 1'b0;

    vt.push_back(mk("add_5_7", 4'd0, 32'd5, 32'd7, 4'd3, 1,
                    32'd12, 0, 0, 0, 0, 1));
    vt.push_back(mk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd4, 1,
                    32'd0, 1, 0, 1, 0, 1));
    vt.push_back(mk("sub_eq", 4'd1, 32'd3, 32'd3, 4'd5, 1,
                    32'd0, 1, 0, 1, 0, 1));
    vt.push_back(mk("sub_borrow", 4'd1, 32'd3, 32'd5, 4'd6, 1,
                    32'hFFFF_FFFE, 0, 1, 0, 0, 1));
    vt.push_back(mk("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7, 1,
                    32'hF000_F000, 0, 1, 0, 0, 1));
    vt.push_back(mk("or", 4'd3, 32'h0000_000F, 32'h0000_00F0, 4'd8, 0,
                    32'h0000_00FF, 0, 0, 0, 0, 0));
    vt.push_back(mk("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 4'd9, 1,
                    32'h5555_5555, 0, 0, 0, 0, 1));
    vt.push_back(mk("sll_mask", 4'd5, 32'd1, 32'h24, 4'd10, 1,
                    32'h10, 0, 0, 0, 0, 1));
    vt.push_back(mk("srl_31", 4'd6, 32'h8000_0000, 32'd31, 4'd11, 1,
                    32'd1, 0, 0, 0, 0, 1));
    vt.push_back(mk("sra_4", 4'd7, 32'h8000_0000, 32'd4, 4'd12, 1,
                    32'hF800_0000, 0, 1, 0, 0, 1));
    vt.push_back(mk("passb", 4'd11, 32'd0, 32'h1234, 4'd13, 1,
                    32'h1234, 0, 0, 0, 0, 1));
    vt.push_back(mk("illegal13", 4'd13, 32'd9, 32'd9, 4'd14, 1,
                    32'd0, 1, 0, 0, 1, 0));
`ifndef EXU_DIV_EN
    vt.push_back(mk("div_off", 4'd9, 32'd100, 32'd7, 4'd1, 1,
                    32'd0, 1, 0, 0, 1, 0));
    vt.push_back(mk("mod_off", 4'd10, 32'd100, 32'd7, 4'd2, 1,
                    32'd0, 1, 0, 0, 1, 0));
`endif
    vt.push_back(mk("add_last", 4'd0, 32'h10, 32'h20, 4'd15, 1,
                    32'h30, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset",
        {20'd0, in_ready, out_valid, result, flag_z, flag_n, flag_c,
         illegal, wr_out, rd_out},
        {20'd0, 1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0});
    @(negedge clk) rst = 1'b0;

    // Issued back to back: in_valid stays high across the whole table
    foreach (vt[i]) apply_vec(vt[i]);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold", {31'd0, out_valid, wr_out, result},
        {31'd0, 1'b0, 1'b0, 32'h30});

    run_multi("mul_big", 4'd8, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
    run_multi("mul_7x6", 4'd8, 32'd7, 32'd6, 32'd42);
`ifdef EXU_DIV_EN
    run_multi("div_100_7", 4'd9, 32'd100, 32'd7, 32'd14);
    run_multi("mod_100_7", 4'd10, 32'd100, 32'd7, 32'd2);
    run_multi("div_by_0", 4'd9, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_multi("mod_by_0", 4'd10, 32'd5, 32'd0, 32'd5);
`endif

    // Reset in the middle of a multiply
    @(negedge clk);
    drive(4'd8, 32'd3, 32'd5, 4'd6, 1'b1);
    @(posedge clk); #1;
    @(negedge clk) in_valid = 1'b0;
    bad = 0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid || wr_out) bad++;
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 40; k++) begin
      if (out_valid || wr_out) bad++;
      @(posedge clk); #1;
    end
    chk("rst_no_out", 64'(bad), 64'd0);
    apply_vec(mk("add_after_rst", 4'd0, 32'd2, 32'd3, 4'd1, 1,
                 32'd5, 0, 0, 0, 0, 1));
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
